// File: rtl/tft_spi_rx_decoder_if.sv
// SPI snoop inputs and decoded outputs of the TFT link receiver.
// The master modport drives the link and observes results; the slave modport is the decoder.
interface tft_spi_rx_decoder_if;
    logic        TFT_CLK;
    logic        TFT_CS;
    logic        TFT_DCX;
    logic        TFT_MOSI;
    logic        CMD_VALID;
    logic [7:0]  CMD_BYTE;
    logic        PIX_VALID;
    logic [7:0]  PIX_X;
    logic [7:0]  PIX_Y;
    logic [15:0] PIX_COLOR;
    logic [7:0]  COLMOD;
    logic [15:0] PIX_COUNT;
    logic        FRAME_ERR;

    modport master (
        output TFT_CLK, TFT_CS, TFT_DCX, TFT_MOSI,
        input  CMD_VALID, CMD_BYTE, PIX_VALID, PIX_X, PIX_Y,
        input  PIX_COLOR, COLMOD, PIX_COUNT, FRAME_ERR
    );

    modport slave (
        input  TFT_CLK, TFT_CS, TFT_DCX, TFT_MOSI,
        output CMD_VALID, CMD_BYTE, PIX_VALID, PIX_X, PIX_Y,
        output PIX_COLOR, COLMOD, PIX_COUNT, FRAME_ERR
    );
endinterface

// File: rtl/tft_spi_rx_decoder.sv
// Receiving end of the TFT SPI link: rebuilds bytes, tracks the CASET/RASET window
// and emits one decoded RGB565 pixel with its (x, y) address per RAMWR pixel pair.
module tft_spi_rx_decoder #(
    parameter logic [7:0] COL_END_DEF = 8'd127,
    parameter logic [7:0] ROW_END_DEF = 8'd159,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  FPGA_CLK,
    input  logic                  TFT_DIV_COUNTER_RESET,
    tft_spi_rx_decoder_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET_P,
        S_RASET_P,
        S_COLMOD_P,
        S_RAMWR_HI,
        S_RAMWR_LO
    } state_t;

    // Sync vector layout: {clk, cs, dcx, mosi}; CS idles deasserted.
    localparam logic [3:0] SYNC_RST = 4'b0100;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic        clk_prev_q, clk_prev_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_valid_q, byte_valid_d;
    logic        byte_dcx_q, byte_dcx_d;
    logic        frame_err_q, frame_err_d;

    state_t      state_q, state_d;
    logic [1:0]  param_idx_q, param_idx_d;
    logic [7:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [7:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] pix_color_q, pix_color_d;
    logic [15:0] pix_count_q, pix_count_d;
    logic [7:0]  colmod_q, colmod_d;
    logic [7:0]  cmd_byte_q, cmd_byte_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        pix_valid_q, pix_valid_d;

    logic clk_s, cs_s, dcx_s, mosi_s;

    assign clk_s  = sync_q[SYNC_STAGES-1][3];
    assign cs_s   = sync_q[SYNC_STAGES-1][2];
    assign dcx_s  = sync_q[SYNC_STAGES-1][1];
    assign mosi_s = sync_q[SYNC_STAGES-1][0];

    always_comb begin
        sync_d       = sync_q;
        sync_d[0]    = {bus.TFT_CLK, bus.TFT_CS, bus.TFT_DCX, bus.TFT_MOSI};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        clk_prev_d   = clk_s;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        byte_dcx_d   = byte_dcx_q;
        frame_err_d  = 1'b0;
        // The counter clears on the first synced CS-high cycle, so a partial byte flags exactly once.
        if (cs_s) begin
            bit_cnt_d   = 3'd0;
            frame_err_d = (bit_cnt_q != 3'd0);
        end else if (clk_s && !clk_prev_q) begin
            shift_d = {shift_q[6:0], mosi_s};
            if (bit_cnt_q == 3'd7) begin
                bit_cnt_d    = 3'd0;
                byte_valid_d = 1'b1;
                byte_dcx_d   = dcx_s;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        param_idx_d = param_idx_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        hi_d        = hi_q;
        pix_color_d = pix_color_q;
        pix_count_d = pix_count_q;
        colmod_d    = colmod_q;
        cmd_byte_d  = cmd_byte_q;
        cmd_valid_d = 1'b0;
        pix_valid_d = 1'b0;

        // Address advances the cycle after a pixel; bytes are far apart, so no collision with a command.
        if (pix_valid_q) begin
            if (pix_x_q == xe_q) begin
                pix_x_d = xs_q;
                pix_y_d = (pix_y_q == ye_q) ? ys_q : pix_y_q + 8'd1;
            end else begin
                pix_x_d = pix_x_q + 8'd1;
            end
        end

        if (byte_valid_q) begin
            if (!byte_dcx_q) begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = shift_q;
                param_idx_d = 2'd0;
                case (shift_q)
                    8'h2A: state_d = S_CASET_P;
                    8'h2B: state_d = S_RASET_P;
                    8'h2C: begin
                        state_d     = S_RAMWR_HI;
                        pix_x_d     = xs_q;
                        pix_y_d     = ys_q;
                        pix_count_d = 16'd0;
                    end
                    8'h3A: state_d = S_COLMOD_P;
                    8'h01: begin
                        state_d = S_IDLE;
                        xs_d    = 8'd0;
                        xe_d    = COL_END_DEF;
                        ys_d    = 8'd0;
                        ye_d    = ROW_END_DEF;
                    end
                    default: state_d = S_IDLE;
                endcase
            end else begin
                case (state_q)
                    S_CASET_P, S_RASET_P: begin
                        param_idx_d = param_idx_q + 2'd1;
                        if (param_idx_q == 2'd1) begin
                            if (state_q == S_CASET_P) xs_d = shift_q;
                            else                      ys_d = shift_q;
                        end
                        if (param_idx_q == 2'd3) begin
                            if (state_q == S_CASET_P) xe_d = shift_q;
                            else                      ye_d = shift_q;
                            state_d = S_IDLE;
                        end
                    end
                    S_COLMOD_P: begin
                        colmod_d = shift_q;
                        state_d  = S_IDLE;
                    end
                    S_RAMWR_HI: begin
                        hi_d    = shift_q;
                        state_d = S_RAMWR_LO;
                    end
                    S_RAMWR_LO: begin
                        pix_color_d = {hi_q, shift_q};
                        pix_valid_d = 1'b1;
                        pix_count_d = pix_count_q + 16'd1;
                        state_d     = S_RAMWR_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge FPGA_CLK or posedge TFT_DIV_COUNTER_RESET) begin
        if (TFT_DIV_COUNTER_RESET) begin
            sync_q       <= {SYNC_STAGES{SYNC_RST}};
            clk_prev_q   <= 1'b0;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            byte_dcx_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= S_IDLE;
            param_idx_q  <= 2'd0;
            xs_q         <= 8'd0;
            xe_q         <= COL_END_DEF;
            ys_q         <= 8'd0;
            ye_q         <= ROW_END_DEF;
            pix_x_q      <= 8'd0;
            pix_y_q      <= 8'd0;
            hi_q         <= 8'd0;
            pix_color_q  <= 16'd0;
            pix_count_q  <= 16'd0;
            colmod_q     <= 8'd0;
            cmd_byte_q   <= 8'd0;
            cmd_valid_q  <= 1'b0;
            pix_valid_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            clk_prev_q   <= clk_prev_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_dcx_q   <= byte_dcx_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            param_idx_q  <= param_idx_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            hi_q         <= hi_d;
            pix_color_q  <= pix_color_d;
            pix_count_q  <= pix_count_d;
            colmod_q     <= colmod_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

    assign bus.CMD_VALID = cmd_valid_q;
    assign bus.CMD_BYTE  = cmd_byte_q;
    assign bus.PIX_VALID = pix_valid_q;
    assign bus.PIX_X     = pix_x_q;
    assign bus.PIX_Y     = pix_y_q;
    assign bus.PIX_COLOR = pix_color_q;
    assign bus.COLMOD    = colmod_q;
    assign bus.PIX_COUNT = pix_count_q;
    assign bus.FRAME_ERR = frame_err_q;

endmodule
